weight_pingpong_buffer: RTL and testbench
=========================================

// Module: weight_pingpong_buffer
// PURPOSE
//  Two-bank (ping-pong) holding buffer between weight_controller and the PE arrays.
//  Captures a pair of transformed 6x6 weight tiles plus their output-depth tags.
//  Presents the oldest pair to the PE arrays until it has been consumed REUSE times.
//  Lets the next pair load while the current pair is in use.
// PARAMETERS
//  DATA_W  12  bit width of one signed tile element
//  TILE    6   tile edge (TILE x TILE elements per tile)
//  CNT_W   8   width of the reuse counter / reuse_cnt_i
// PORTS
//  clk          in   1               clock, all state on posedge
//  reset        in   1               asynchronous, active-low; clears all state
//  in_valid_i   in   1               write request: tile pair on in_* is valid this cycle
//  in_ready_o   out  1               buffer can accept a pair this cycle
//  in_tile_1_i  in   DATA_W[TILE][TILE]  signed tile for od1
//  in_tile_2_i  in   DATA_W[TILE][TILE]  signed tile for od2
//  in_od1_i     in   8               output-depth tag of tile 1
//  in_od2_i     in   8               output-depth tag of tile 2
//  reuse_cnt_i  in   CNT_W           reads per pair before release, sampled on write
//  out_valid_o  out  1               active bank holds a pair for the PEs
//  out_ready_i  in   1               PE arrays accept one read beat
//  out_tile_1_o out  DATA_W[TILE][TILE]  active bank tile 1
//  out_tile_2_o out  DATA_W[TILE][TILE]  active bank tile 2
//  out_od1_o    out  8               active bank od1 tag
//  out_od2_o    out  8               active bank od2 tag
//  out_last_o   out  1               current beat is the final reuse of this pair
//  occupancy_o  out  2               banks currently full (0..2)
// BEHAVIOUR
//  - Reset (reset==0, async): both banks EMPTY, wr_ptr=rd_ptr=0, reuse counters 0.
//    All out_* data zero, out_valid_o=0, out_last_o=0, occupancy_o=0, in_ready_o=0.
//    in_ready_o goes to 1 in the first cycle after reset deasserts.
//  - Per-bank state: EMPTY -> FULL on write; FULL -> EMPTY on release. One flag per bank.
//  - in_ready_o = registered: bank[wr_ptr] EMPTY. No combinational path from in_valid_i or out_ready_i.
//  - Write fires on in_valid_i && in_ready_o at posedge:
//    - store both tiles, od1, od2 and limit = (reuse_cnt_i==0 ? 1 : reuse_cnt_i);
//    - bank FULL; wr_ptr toggles.
//    - in_valid_i while !in_ready_o is ignored and nothing is stored. The sender must hold the pair.
//  - out_valid_o = bank[rd_ptr] FULL. out_* are driven from bank[rd_ptr] registers via a mux only.
//    Data are stable while out_valid_o=1.
//  - Read beat fires on out_valid_o && out_ready_i. The active bank's used counter increments.
//  - out_last_o = out_valid_o && (used == limit-1).
//  - Release: a beat with out_last_o set clears bank FULL, resets used to 0 and toggles rd_ptr.
//    The next bank, if FULL, is presented in the following cycle. No bubble beyond that one edge.
//  - Latency: pair written at edge N into an empty buffer -> out_valid_o=1 from cycle N+1.
//  - Simultaneous write and release in one cycle are both legal. A write into the other bank plus
//    release of this bank leaves occupancy unchanged.
//  - A bank released at edge N is writable from cycle N+1, because in_ready_o is registered.
//  - occupancy_o = FULL(bank0)+FULL(bank1). Full buffer (2): in_ready_o=0. Empty (0): out_valid_o=0.
//  - Pointer wrap: each 1-bit pointer toggles 0->1->0. Order is strictly FIFO over the two banks.
//  - Reset mid-operation discards both banks, including a partially consumed one.
//    Its remaining reuses are lost. The upstream side must reload.
//  - Arithmetic: counters are unsigned CNT_W. Tiles are passed bit-exact with no sign handling.
// TESTING
//  - Reset: after reset release, all outputs 0 and in_ready_o=1 one cycle later.
//  - Single pair: od1=4, od2=5, reuse=3, out_ready_i held 1 -> 3 beats, out_last_o on beat 3.
//    Then out_valid_o=0 and occupancy 0.
//  - Back-to-back: pairs A(od1=0), B(od1=2), C(od1=4), reuse=2, PEs stalled.
//    -> A and B accepted, C held with in_ready_o=0.
//    -> PEs enabled: order is A,A,B,B, and C is accepted the cycle after A releases.
//  - Simultaneous: write lands on the same edge as the last read of the other bank.
//    -> both take effect; occupancy stays 1; new pair presented the next cycle.
//  - reuse_cnt_i=0 -> exactly 1 beat, with out_last_o=1 on it.
//    Backpressure with out_ready_i toggling 1,0,1 -> tiles stable, counter advances only on beats.
//  - Reset asserted mid-reuse (beat 2 of 4) -> immediate clear.
//    After release, no stale pair is presented (out_valid_o=0).

Source files
------------

// File: rtl/weight_pingpong_buffer.sv
// Two-bank ping-pong holding buffer for transformed weight tile pairs.
// A write fills bank[wr_ptr]; the PEs read bank[rd_ptr] until it has been reused `limit` times.
module weight_pingpong_buffer #(
  parameter int DATA_W = 12,
  parameter int TILE   = 6,
  parameter int CNT_W  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic [TILE-1:0][TILE-1:0][DATA_W-1:0]    in_tile_1_i,
  input  logic [TILE-1:0][TILE-1:0][DATA_W-1:0]    in_tile_2_i,
  input  logic [7:0]                               in_od1_i,
  input  logic [7:0]                               in_od2_i,
  input  logic [CNT_W-1:0]                         reuse_cnt_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [TILE-1:0][TILE-1:0][DATA_W-1:0]    out_tile_1_o,
  output logic [TILE-1:0][TILE-1:0][DATA_W-1:0]    out_tile_2_o,
  output logic [7:0]                               out_od1_o,
  output logic [7:0]                               out_od2_o,
  output logic                                     out_last_o,
  output logic [1:0]                               occupancy_o
);

  typedef logic [TILE-1:0][TILE-1:0][DATA_W-1:0] tile_t;

  tile_t            tile1_r [2];
  tile_t            tile2_r [2];
  logic [7:0]       od1_r   [2];
  logic [7:0]       od2_r   [2];
  logic [CNT_W-1:0] limit_r [2];
  logic [CNT_W-1:0] used_r  [2];
  logic [1:0]       full_r;
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic             in_ready_r;

  logic             fire_wr_s;
  logic             fire_rd_s;
  logic             last_s;
  logic             release_s;
  logic             wr_ptr_next_s;
  logic [1:0]       full_next_s;
  logic [CNT_W-1:0] limit_in_s;

  assign fire_wr_s     = in_valid_i && in_ready_r;
  assign last_s        = full_r[rd_ptr_r] && (used_r[rd_ptr_r] == (limit_r[rd_ptr_r] - CNT_W'(1)));
  assign fire_rd_s     = full_r[rd_ptr_r] && out_ready_i;
  assign release_s     = fire_rd_s && last_s;
  assign wr_ptr_next_s = wr_ptr_r ^ fire_wr_s;
  assign limit_in_s    = (reuse_cnt_i == '0) ? CNT_W'(1) : reuse_cnt_i;

  // Next bank-full flags; a write and a release never target the same bank.
  always_comb begin
    full_next_s = full_r;
    for (int b = 0; b < 2; b++) begin
      if (fire_wr_s && (wr_ptr_r == 1'(b))) begin
        full_next_s[b] = 1'b1;
      end else if (release_s && (rd_ptr_r == 1'(b))) begin
        full_next_s[b] = 1'b0;
      end else begin
        full_next_s[b] = full_r[b];
      end
    end
  end

  // Bank payload storage and per-bank reuse counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        tile1_r[b] <= '0;
        tile2_r[b] <= '0;
        od1_r[b]   <= 8'd0;
        od2_r[b]   <= 8'd0;
        limit_r[b] <= '0;
        used_r[b]  <= '0;
      end
    end else begin
      if (fire_wr_s) begin
        tile1_r[wr_ptr_r] <= in_tile_1_i;
        tile2_r[wr_ptr_r] <= in_tile_2_i;
        od1_r[wr_ptr_r]   <= in_od1_i;
        od2_r[wr_ptr_r]   <= in_od2_i;
        limit_r[wr_ptr_r] <= limit_in_s;
        used_r[wr_ptr_r]  <= '0;
      end
      if (fire_rd_s) begin
        used_r[rd_ptr_r] <= release_s ? '0 : (used_r[rd_ptr_r] + CNT_W'(1));
      end
    end
  end

  // Control state; in_ready is precomputed from next state so a freed bank is writable next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_r     <= 2'b00;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      full_r     <= full_next_s;
      wr_ptr_r   <= wr_ptr_next_s;
      rd_ptr_r   <= rd_ptr_r ^ release_s;
      in_ready_r <= ~full_next_s[wr_ptr_next_s];
    end
  end

  assign in_ready_o   = in_ready_r;
  assign out_valid_o  = full_r[rd_ptr_r];
  assign out_last_o   = last_s;
  assign out_tile_1_o = tile1_r[rd_ptr_r];
  assign out_tile_2_o = tile2_r[rd_ptr_r];
  assign out_od1_o    = od1_r[rd_ptr_r];
  assign out_od2_o    = od2_r[rd_ptr_r];
  assign occupancy_o  = {1'b0, full_r[0]} + {1'b0, full_r[1]};

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed-vector bench for weight_pingpong_buffer with hand-computed expectations.
module tb_weight_pingpong_buffer;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      in_valid_i = 1'b0;
  logic                      in_ready_o;
  logic [5:0][5:0][11:0]     in_tile_1_i = '0;
  logic [5:0][5:0][11:0]     in_tile_2_i = '0;
  logic [7:0]                in_od1_i = 8'd0;
  logic [7:0]                in_od2_i = 8'd0;
  logic [7:0]                reuse_cnt_i = 8'd0;
  logic                      out_valid_o;
  logic                      out_ready_i = 1'b0;
  logic [5:0][5:0][11:0]     out_tile_1_o;
  logic [5:0][5:0][11:0]     out_tile_2_o;
  logic [7:0]                out_od1_o;
  logic [7:0]                out_od2_o;
  logic                      out_last_o;
  logic [1:0]                occupancy_o;

  int checks = 0;
  int failures = 0;

  weight_pingpong_buffer #(.DATA_W(12), .TILE(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_tile_1_i(in_tile_1_i), .in_tile_2_i(in_tile_2_i),
    .in_od1_i(in_od1_i), .in_od2_i(in_od2_i), .reuse_cnt_i(reuse_cnt_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_tile_1_o(out_tile_1_o), .out_tile_2_o(out_tile_2_o),
    .out_od1_o(out_od1_o), .out_od2_o(out_od2_o),
    .out_last_o(out_last_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0][5:0][11:0] mk(input int s);
    logic [5:0][5:0][11:0] t;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        t[i][j] = 12'(s * 37 + i * 6 + j) ^ 12'h800;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input int s, input logic [7:0] od1, input logic [7:0] od2, input logic [7:0] reuse);
    in_valid_i  = 1'b1;
    in_tile_1_i = mk(s);
    in_tile_2_i = mk(s + 100);
    in_od1_i    = od1;
    in_od2_i    = od2;
    reuse_cnt_i = reuse;
  endtask

  initial begin
    // reset state
    tick(); tick();
    check_val("rst_valid", out_valid_o, 1'b0);
    check_val("rst_ready", in_ready_o, 1'b0);
    check_val("rst_occ", occupancy_o, 2'd0);
    check_val("rst_last", out_last_o, 1'b0);
    check_val("rst_od1", out_od1_o, 8'd0);
    check_val("rst_tile1", out_tile_1_o, '0);
    reset = 1'b1;
    check_val("ready_before_edge", in_ready_o, 1'b0);
    tick();
    check_val("ready_after_rst", in_ready_o, 1'b1);

    // single pair, reuse 3
    drive_pair(1, 8'd4, 8'd5, 8'd3);
    out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check_val("sp_valid", out_valid_o, 1'b1);
    check_val("sp_od1", out_od1_o, 8'd4);
    check_val("sp_od2", out_od2_o, 8'd5);
    check_val("sp_tile1", out_tile_1_o, mk(1));
    check_val("sp_tile2", out_tile_2_o, mk(101));
    check_val("sp_occ", occupancy_o, 2'd1);
    check_val("sp_last_b1", out_last_o, 1'b0);
    check_val("sp_ready", in_ready_o, 1'b1);
    tick();
    check_val("sp_last_b2", out_last_o, 1'b0);
    tick();
    check_val("sp_last_b3", out_last_o, 1'b1);
    tick();
    check_val("sp_done_valid", out_valid_o, 1'b0);
    check_val("sp_done_occ", occupancy_o, 2'd0);

    // back-to-back A, B, C with PEs stalled
    out_ready_i = 1'b0;
    drive_pair(2, 8'd0, 8'd1, 8'd2);
    tick();
    check_val("bb_ready_a", in_ready_o, 1'b1);
    drive_pair(3, 8'd2, 8'd3, 8'd2);
    tick();
    check_val("bb_occ_ab", occupancy_o, 2'd2);
    check_val("bb_ready_full", in_ready_o, 1'b0);
    drive_pair(4, 8'd4, 8'd6, 8'd2);
    tick();
    check_val("bb_c_held", in_ready_o, 1'b0);
    check_val("bb_head_a", out_od1_o, 8'd0);
    check_val("bb_tile_a", out_tile_1_o, mk(2));
    check_val("bb_last_stall", out_last_o, 1'b0);
    out_ready_i = 1'b1;
    tick();
    check_val("bb_a2_od1", out_od1_o, 8'd0);
    check_val("bb_a2_last", out_last_o, 1'b1);
    check_val("bb_a2_ready", in_ready_o, 1'b0);
    tick();
    check_val("bb_b1_od1", out_od1_o, 8'd2);
    check_val("bb_b1_last", out_last_o, 1'b0);
    check_val("bb_rel_ready", in_ready_o, 1'b1);
    check_val("bb_rel_occ", occupancy_o, 2'd1);
    tick();
    in_valid_i = 1'b0;
    check_val("bb_c_acc_occ", occupancy_o, 2'd2);
    check_val("bb_b2_od1", out_od1_o, 8'd2);
    check_val("bb_b2_last", out_last_o, 1'b1);
    tick();
    check_val("bb_c_od1", out_od1_o, 8'd4);
    check_val("bb_c_tile2", out_tile_2_o, mk(104));
    check_val("bb_c_occ", occupancy_o, 2'd1);
    tick();
    check_val("bb_c_last", out_last_o, 1'b1);

    // simultaneous write of D with C's final read
    drive_pair(7, 8'd7, 8'd8, 8'd1);
    tick();
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    check_val("sim_occ", occupancy_o, 2'd1);
    check_val("sim_valid", out_valid_o, 1'b1);
    check_val("sim_od1", out_od1_o, 8'd7);
    check_val("sim_ready", in_ready_o, 1'b1);
    check_val("sim_last_r1", out_last_o, 1'b1);
    tick();
    check_val("sim_stall_od1", out_od1_o, 8'd7);
    out_ready_i = 1'b1;
    tick();
    check_val("sim_drain_occ", occupancy_o, 2'd0);

    // reuse 0 behaves as a single beat
    out_ready_i = 1'b0;
    drive_pair(9, 8'd9, 8'd10, 8'd0);
    tick();
    in_valid_i = 1'b0;
    check_val("r0_last", out_last_o, 1'b1);
    out_ready_i = 1'b1;
    tick();
    check_val("r0_valid", out_valid_o, 1'b0);
    check_val("r0_occ", occupancy_o, 2'd0);

    // backpressure with out_ready 1,0,1
    out_ready_i = 1'b0;
    drive_pair(5, 8'd11, 8'd12, 8'd3);
    tick();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    tick();
    check_val("bp_no_adv", out_last_o, 1'b0);
    check_val("bp_tile_stable", out_tile_1_o, mk(5));
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check_val("bp_adv_last", out_last_o, 1'b1);
    check_val("bp_tile_stable2", out_tile_2_o, mk(105));
    out_ready_i = 1'b1;
    tick();
    check_val("bp_done", out_valid_o, 1'b0);

    // reset mid-reuse (beat 2 of 4), other bank also full
    drive_pair(6, 8'd20, 8'd21, 8'd4);
    tick();
    drive_pair(8, 8'd22, 8'd23, 8'd4);
    tick();
    in_valid_i = 1'b0;
    tick();
    check_val("mr_head", out_od1_o, 8'd20);
    check_val("mr_occ", occupancy_o, 2'd2);
    check_val("mr_last", out_last_o, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_val("mr_clr_valid", out_valid_o, 1'b0);
    check_val("mr_clr_occ", occupancy_o, 2'd0);
    check_val("mr_clr_ready", in_ready_o, 1'b0);
    check_val("mr_clr_od1", out_od1_o, 8'd0);
    tick();
    reset = 1'b1;
    tick();
    check_val("mr_post_valid", out_valid_o, 1'b0);
    check_val("mr_post_ready", in_ready_o, 1'b1);
    check_val("mr_post_occ", occupancy_o, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
